conv_layer_sequencer: RTL and testbench

- Parametrised successor to the single-tile TDM pass controller; sequences a complete conv layer on the systolic datapath.
- Runs three nested loops: output-channel tiles of K_CHANNELS, then input-channel passes, then output rows.
- Each row is started on the ARR/input buffer and waited for; pass, drain and layer boundaries are handled explicitly.
- Sits between the layer-level host FSM and the IB/ARR/weight scheduler/result handler; drives accumulation gating and weight base addresses.

---
 rtl/conv_layer_sequencer_pkg.sv | 32 +++
 rtl/conv_layer_sequencer_seq_loop_counters.sv | 100 ++++++++++
 rtl/conv_layer_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the conv layer sequencer: state encoding, datapath
// constants and the output-tile channel mask helper.
package conv_layer_sequencer_pkg;

    localparam int INT_WIDTH  = 32;
    localparam int K_CHANNELS = 6;
    localparam int MAX_K      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ROW_START,
        ST_ROW_WAIT,
        ST_PASS_SETUP,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // Mask with min(live, k) low bits set; callers truncate to their own K.
    function automatic logic [MAX_K-1:0] tile_mask(input int unsigned live,
                                                   input int unsigned k);
        int unsigned      n;
        logic [MAX_K-1:0] m;
        n = (live < k) ? live : k;
        m = '0;
        for (int unsigned i = 0; i < MAX_K; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_seq_loop_counters.sv
// Row / input-channel / output-tile loop counters with terminal flags,
// the live-channel mask of the current tile and the weight base accumulator.
module conv_layer_sequencer_seq_loop_counters #(
    parameter int PTR_WIDTH  = conv_layer_sequencer_pkg::INT_WIDTH,
    parameter int CH_W       = 16,
    parameter int K_CHANNELS = conv_layer_sequencer_pkg::K_CHANNELS,
    parameter int WADDR_W    = 16,
    parameter int TILE_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_async_n_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  row_inc_i,
    input  logic                  pass_adv_i,
    input  logic                  tile_adv_i,
    input  logic [PTR_WIDTH-1:0]  cfg_img_h_i,
    input  logic [3:0]            cfg_kernel_r_i,
    input  logic [CH_W-1:0]       cfg_num_in_ch_i,
    input  logic [CH_W-1:0]       cfg_num_out_ch_i,
    input  logic [WADDR_W-1:0]    cfg_wt_pass_stride_i,
    output logic                  row_last_o,
    output logic [CH_W-1:0]       in_ch_o,
    output logic                  in_ch_last_o,
    output logic [TILE_W-1:0]     tile_o,
    output logic                  tile_last_o,
    output logic [K_CHANNELS-1:0] tile_mask_o,
    output logic [WADDR_W-1:0]    wt_base_o
);
    import conv_layer_sequencer_pkg::*;

    logic [PTR_WIDTH-1:0]  row_q;
    logic [PTR_WIDTH-1:0]  rows_total_q;
    logic [CH_W-1:0]       in_ch_q;
    logic [CH_W-1:0]       out_rem_q;
    logic [TILE_W-1:0]     tile_q;
    logic [K_CHANNELS-1:0] mask_q;
    logic [WADDR_W-1:0]    wt_base_q;
    logic [K_CHANNELS-1:0] load_mask;
    logic [K_CHANNELS-1:0] next_mask;

    // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latch is inferred.
    always_comb begin
        load_mask = K_CHANNELS'(tile_mask(32'(cfg_num_out_ch_i), K_CHANNELS));
        next_mask = K_CHANNELS'(tile_mask(32'(out_rem_q - CH_W'(K_CHANNELS)), K_CHANNELS));
    end

    // Remaining output channels shrink by K per tile: the ceil(out/K) tile
    // count falls out of subtract-compare without ever dividing.
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            row_q        <= '0;
            rows_total_q <= '0;
            in_ch_q      <= '0;
            out_rem_q    <= '0;
            tile_q       <= '0;
            mask_q       <= '0;
            wt_base_q    <= '0;
        end else if (clear_i) begin
            row_q        <= '0;
            rows_total_q <= '0;
            in_ch_q      <= '0;
            out_rem_q    <= '0;
            tile_q       <= '0;
            mask_q       <= '0;
            wt_base_q    <= '0;
        end else if (load_i) begin
            row_q        <= '0;
            rows_total_q <= cfg_img_h_i - PTR_WIDTH'(cfg_kernel_r_i) + PTR_WIDTH'(1);
            in_ch_q      <= '0;
            out_rem_q    <= cfg_num_out_ch_i;
            tile_q       <= '0;
            mask_q       <= load_mask;
            wt_base_q    <= '0;
        end else if (tile_adv_i) begin
            row_q        <= '0;
            in_ch_q      <= '0;
            out_rem_q    <= out_rem_q - CH_W'(K_CHANNELS);
            tile_q       <= tile_q + TILE_W'(1);
            mask_q       <= next_mask;
            wt_base_q    <= wt_base_q + cfg_wt_pass_stride_i;
        end else if (pass_adv_i) begin
            row_q        <= '0;
            in_ch_q      <= in_ch_q + CH_W'(1);
            wt_base_q    <= wt_base_q + cfg_wt_pass_stride_i;
        end else if (row_inc_i) begin
            row_q        <= row_q + PTR_WIDTH'(1);
        end
    end

    assign row_last_o   = ((row_q + PTR_WIDTH'(1)) == rows_total_q);
    assign in_ch_last_o = (in_ch_q == (cfg_num_in_ch_i - CH_W'(1)));
    assign tile_last_o  = (out_rem_q <= CH_W'(K_CHANNELS));
    assign in_ch_o      = in_ch_q;
    assign tile_o       = tile_q;
    assign tile_mask_o  = mask_q;
    assign wt_base_o    = wt_base_q;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer-level sequencer for the systolic conv datapath: walks output tiles,
// input-channel passes and output rows, handshaking each row with the ARR.
module conv_layer_sequencer #(
    parameter int PTR_WIDTH  = conv_layer_sequencer_pkg::INT_WIDTH,
    parameter int CH_W       = 16,
    parameter int K_CHANNELS = conv_layer_sequencer_pkg::K_CHANNELS,
    parameter int WADDR_W    = 16,
    parameter int TILE_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_async_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [PTR_WIDTH-1:0]  cfg_img_h_i,
    input  logic [3:0]            cfg_kernel_r_i,
    input  logic [CH_W-1:0]       cfg_num_in_ch_i,
    input  logic [CH_W-1:0]       cfg_num_out_ch_i,
    input  logic [WADDR_W-1:0]    cfg_wt_pass_stride_i,
    input  logic                  row_done_i,
    input  logic                  rh_idle_i,
    output logic                  row_start_o,
    output logic                  ib_rst_o,
    output logic [CH_W-1:0]       in_ch_sel_o,
    output logic [TILE_W-1:0]     tile_idx_o,
    output logic [K_CHANNELS-1:0] tile_valid_ch_o,
    output logic [WADDR_W-1:0]    wt_base_o,
    output logic                  last_pass_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    import conv_layer_sequencer_pkg::*;

    seq_state_e state_q;

    logic [PTR_WIDTH-1:0] img_h_q;
    logic [3:0]           kernel_r_q;
    logic [CH_W-1:0]      num_in_ch_q;
    logic [CH_W-1:0]      num_out_ch_q;
    logic [WADDR_W-1:0]   stride_q;

    logic abort_act;
    logic cfg_err;
    logic single_pass;
    logic ctr_clear;
    logic ctr_load;
    logic ctr_row_inc;
    logic ctr_pass_adv;
    logic ctr_tile_adv;
    logic row_last;
    logic in_ch_last;
    logic tile_last;

    // Counter strobes fire on the same edge as the matching state transition.
    always_comb begin
        abort_act    = abort_i && (state_q != ST_IDLE);
        cfg_err      = (num_in_ch_q == '0) || (num_out_ch_q == '0) || (kernel_r_q == '0) ||
                       (PTR_WIDTH'(kernel_r_q) > img_h_q);
        single_pass  = (num_in_ch_q == CH_W'(1));
        ctr_clear    = abort_act || (state_q == ST_DONE);
        ctr_load     = !abort_act && (state_q == ST_CHECK) && !cfg_err;
        ctr_row_inc  = !abort_act && (state_q == ST_ROW_WAIT) && row_done_i;
        ctr_pass_adv = ctr_row_inc && row_last && !in_ch_last;
        ctr_tile_adv = !abort_act && (state_q == ST_DRAIN) && rh_idle_i && !tile_last;
    end

    // NOTE: the shadow config is async-reset with the FSM so nothing is X after reset.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q      <= ST_IDLE;
            img_h_q      <= '0;
            kernel_r_q   <= '0;
            num_in_ch_q  <= '0;
            num_out_ch_q <= '0;
            stride_q     <= '0;
            row_start_o  <= 1'b0;
            ib_rst_o     <= 1'b0;
            last_pass_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            row_start_o <= 1'b0;
            ib_rst_o    <= 1'b0;
            done_o      <= 1'b0;
            last_pass_o <= 1'b0;
            if (abort_act) begin
                state_q  <= ST_IDLE;
                ib_rst_o <= 1'b1;
                busy_o   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            img_h_q      <= cfg_img_h_i;
                            kernel_r_q   <= cfg_kernel_r_i;
                            num_in_ch_q  <= cfg_num_in_ch_i;
                            num_out_ch_q <= cfg_num_out_ch_i;
                            stride_q     <= cfg_wt_pass_stride_i;
                            err_o        <= 1'b0;
                            busy_o       <= 1'b1;
                            state_q      <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (cfg_err) begin
                            err_o   <= 1'b1;
                            busy_o  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            row_start_o <= 1'b1;
                            last_pass_o <= single_pass;
                            state_q     <= ST_ROW_START;
                        end
                    end
                    ST_ROW_START: begin
                        last_pass_o <= in_ch_last;
                        state_q     <= ST_ROW_WAIT;
                    end
                    ST_ROW_WAIT: begin
                        if (!row_done_i) begin
                            last_pass_o <= in_ch_last;
                        end else if (!row_last) begin
                            row_start_o <= 1'b1;
                            last_pass_o <= in_ch_last;
                            state_q     <= ST_ROW_START;
                        end else if (!in_ch_last) begin
                            ib_rst_o <= 1'b1;
                            state_q  <= ST_PASS_SETUP;
                        end else begin
                            last_pass_o <= 1'b1;
                            state_q     <= ST_DRAIN;
                        end
                    end
                    ST_PASS_SETUP: begin
                        // in_ch already advanced on entry, so in_ch_last is current.
                        row_start_o <= 1'b1;
                        last_pass_o <= in_ch_last;
                        state_q     <= ST_ROW_START;
                    end
                    ST_DRAIN: begin
                        if (!rh_idle_i) begin
                            last_pass_o <= in_ch_last;
                        end else if (!tile_last) begin
                            ib_rst_o    <= 1'b1;
                            row_start_o <= 1'b1;
                            last_pass_o <= single_pass;
                            state_q     <= ST_ROW_START;
                        end else begin
                            ib_rst_o <= 1'b1;
                            done_o   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        busy_o  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        busy_o  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    conv_layer_sequencer_seq_loop_counters #(
        .PTR_WIDTH  (PTR_WIDTH),
        .CH_W       (CH_W),
        .K_CHANNELS (K_CHANNELS),
        .WADDR_W    (WADDR_W),
        .TILE_W     (TILE_W)
    ) u_seq_loop_counters (
        .clk_i                (clk_i),
        .rst_async_n_i        (rst_async_n_i),
        .clear_i              (ctr_clear),
        .load_i               (ctr_load),
        .row_inc_i            (ctr_row_inc),
        .pass_adv_i           (ctr_pass_adv),
        .tile_adv_i           (ctr_tile_adv),
        .cfg_img_h_i          (img_h_q),
        .cfg_kernel_r_i       (kernel_r_q),
        .cfg_num_in_ch_i      (num_in_ch_q),
        .cfg_num_out_ch_i     (num_out_ch_q),
        .cfg_wt_pass_stride_i (stride_q),
        .row_last_o           (row_last),
        .in_ch_o              (in_ch_sel_o),
        .in_ch_last_o         (in_ch_last),
        .tile_o               (tile_idx_o),
        .tile_last_o          (tile_last),
        .tile_mask_o          (tile_valid_ch_o),
        .wt_base_o            (wt_base_o)
    );

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: a loop-nest model predicts every
// row start (tile, pass, weight base, mask, last-pass) for each layer.
module tb_conv_layer_sequencer;

    localparam int K         = 6;
    localparam int ROW_DELAY = 10;

    logic        clk_i = 1'b0;
    logic        rst_async_n_i;
    logic        start_i;
    logic        abort_i;
    logic [31:0] cfg_img_h_i;
    logic [3:0]  cfg_kernel_r_i;
    logic [15:0] cfg_num_in_ch_i;
    logic [15:0] cfg_num_out_ch_i;
    logic [15:0] cfg_wt_pass_stride_i;
    logic        row_done_i;
    logic        rh_idle_i;
    logic        row_start_o;
    logic        ib_rst_o;
    logic [15:0] in_ch_sel_o;
    logic [7:0]  tile_idx_o;
    logic [5:0]  tile_valid_ch_o;
    logic [15:0] wt_base_o;
    logic        last_pass_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    conv_layer_sequencer dut (
        .clk_i                (clk_i),
        .rst_async_n_i        (rst_async_n_i),
        .start_i              (start_i),
        .abort_i              (abort_i),
        .cfg_img_h_i          (cfg_img_h_i),
        .cfg_kernel_r_i       (cfg_kernel_r_i),
        .cfg_num_in_ch_i      (cfg_num_in_ch_i),
        .cfg_num_out_ch_i     (cfg_num_out_ch_i),
        .cfg_wt_pass_stride_i (cfg_wt_pass_stride_i),
        .row_done_i           (row_done_i),
        .rh_idle_i            (rh_idle_i),
        .row_start_o          (row_start_o),
        .ib_rst_o             (ib_rst_o),
        .in_ch_sel_o          (in_ch_sel_o),
        .tile_idx_o           (tile_idx_o),
        .tile_valid_ch_o      (tile_valid_ch_o),
        .wt_base_o            (wt_base_o),
        .last_pass_o          (last_pass_o),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .err_o                (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int tile;
        int in_ch;
        int wt;
        int last;
        int mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   rs_cnt   = 0;
    int   ib_cnt   = 0;
    int   done_cnt = 0;
    int   last_wt  = 0;
    int   last_mask = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Loop-nest model: tiles outermost, then input-channel passes, then rows.
    task automatic build_model(input int img_h, input int r, input int nin,
                               input int nout, input int stride);
        int   rows;
        int   tiles;
        int   rem;
        exp_t e;
        rows  = img_h - r + 1;
        tiles = (nout + K - 1) / K;
        exp_q.delete();
        for (int t = 0; t < tiles; t++) begin
            rem = nout - t * K;
            for (int c = 0; c < nin; c++) begin
                for (int w = 0; w < rows; w++) begin
                    e.tile  = t;
                    e.in_ch = c;
                    e.wt    = ((t * nin + c) * stride) % 65536;
                    e.last  = (c == nin - 1) ? 1 : 0;
                    e.mask  = (rem >= K) ? ((1 << K) - 1) : ((1 << rem) - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Compare process: every row_start_o pulse must match the next model entry.
    always @(negedge clk_i) begin
        if (rst_async_n_i) begin
            if (ib_rst_o) ib_cnt++;
            if (done_o)   done_cnt++;
            if (row_start_o) begin
                exp_t e;
                rs_cnt++;
                check("row_start_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tile_idx", tile_idx_o, e.tile);
                    check("in_ch_sel", in_ch_sel_o, e.in_ch);
                    check("wt_base", wt_base_o, e.wt);
                    check("last_pass", last_pass_o, e.last);
                    check("tile_valid_ch", tile_valid_ch_o, e.mask);
                end
                last_wt   = wt_base_o;
                last_mask = tile_valid_ch_o;
            end
        end
    end

    task automatic set_cfg(input int img_h, input int r, input int nin,
                           input int nout, input int stride);
        cfg_img_h_i          = img_h;
        cfg_kernel_r_i       = 4'(r);
        cfg_num_in_ch_i      = 16'(nin);
        cfg_num_out_ch_i     = 16'(nout);
        cfg_wt_pass_stride_i = 16'(stride);
    endtask

    task automatic pulse_start();
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    task automatic wait_row_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (row_start_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic serve_rows(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_row_start(ok);
            check("row_start_seen", ok, 1);
            if (!ok) return;
            repeat (ROW_DELAY) @(posedge clk_i);
            #1 row_done_i = 1'b1;
            @(posedge clk_i); #1 row_done_i = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", got, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs0, ib0, dn0;
        bit ok;
        rst_async_n_i = 1'b0;
        start_i       = 1'b0;
        abort_i       = 1'b0;
        row_done_i    = 1'b0;
        rh_idle_i     = 1'b1;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_i);
        #1 rst_async_n_i = 1'b1;
        @(negedge clk_i);
        check("reset_outputs",
              {row_start_o, ib_rst_o, in_ch_sel_o, tile_idx_o, tile_valid_ch_o,
               wt_base_o, last_pass_o, busy_o, done_o, err_o}, 0);

        // Layer 1: single input channel, single tile, drain held off.
        set_cfg(28, 5, 1, 6, 25);
        rh_idle_i = 1'b0;
        build_model(28, 5, 1, 6, 25);
        rs0 = rs_cnt; ib0 = ib_cnt; dn0 = done_cnt;
        pulse_start();
        @(negedge clk_i);
        check("l1_busy", busy_o, 1);
        serve_rows(24);
        repeat (20) @(negedge clk_i);
        check("l1_no_done_while_drain", done_cnt - dn0, 0);
        check("l1_busy_in_drain", busy_o, 1);
        rh_idle_i = 1'b1;
        wait_done();
        @(negedge clk_i);
        check("l1_idle_after_done", busy_o, 0);
        repeat (2) @(negedge clk_i);
        check("l1_row_starts", rs_cnt - rs0, 24);
        check("l1_ib_rst", ib_cnt - ib0, 1);
        check("l1_done_pulses", done_cnt - dn0, 1);
        check("l1_model_drained", exp_q.size(), 0);

        // Layer 2: 3 tiles x 6 passes x 10 rows, cfg scrambled after start.
        set_cfg(14, 5, 6, 16, 150);
        rh_idle_i = 1'b0;
        build_model(14, 5, 6, 16, 150);
        check("l2_model_size", exp_q.size(), 180);
        rs0 = rs_cnt; ib0 = ib_cnt; dn0 = done_cnt;
        pulse_start();
        set_cfg(3, 2, 1, 1, 7);
        serve_rows(60);
        repeat (50) @(negedge clk_i);
        check("l2_stalled_rows", rs_cnt - rs0, 60);
        check("l2_stalled_tile", tile_idx_o, 0);
        check("l2_stalled_done", done_cnt - dn0, 0);
        rh_idle_i = 1'b1;
        serve_rows(120);
        wait_done();
        repeat (2) @(negedge clk_i);
        check("l2_row_starts", rs_cnt - rs0, 180);
        check("l2_ib_rst", ib_cnt - ib0, 18);
        check("l2_done_pulses", done_cnt - dn0, 1);
        check("l2_last_wt_base", last_wt, 2550);
        check("l2_last_mask", last_mask, 6'b001111);
        check("l2_model_drained", exp_q.size(), 0);
        check("l2_busy_low", busy_o, 0);

        // Layer 3: R > img_h is rejected in CHECK.
        set_cfg(5, 7, 1, 6, 25);
        exp_q.delete();
        rs0 = rs_cnt; dn0 = done_cnt;
        pulse_start();
        @(negedge clk_i);
        check("l3_err_not_yet", err_o, 0);
        check("l3_busy_in_check", busy_o, 1);
        @(negedge clk_i);
        check("l3_err_set", err_o, 1);
        check("l3_busy_dropped", busy_o, 0);
        repeat (10) @(negedge clk_i);
        check("l3_no_row_start", rs_cnt - rs0, 0);
        check("l3_err_sticky", err_o, 1);
        check("l3_no_done", done_cnt - dn0, 0);

        // Layer 4: abort in pass 3 coincident with row_done_i.
        set_cfg(14, 5, 6, 16, 150);
        build_model(14, 5, 6, 16, 150);
        rs0 = rs_cnt; ib0 = ib_cnt; dn0 = done_cnt;
        pulse_start();
        @(negedge clk_i);
        check("l4_err_cleared", err_o, 0);
        serve_rows(20);
        wait_row_start(ok);
        check("l4_pass3_start", ok, 1);
        repeat (3) @(posedge clk_i);
        check("l4_in_pass3", in_ch_sel_o, 2);
        #1 row_done_i = 1'b1; abort_i = 1'b1;
        @(posedge clk_i); #1 row_done_i = 1'b0; abort_i = 1'b0;
        @(negedge clk_i);
        check("l4_abort_busy", busy_o, 0);
        check("l4_abort_ib_rst", ib_rst_o, 1);
        check("l4_abort_no_done", done_o, 0);
        check("l4_abort_in_ch", in_ch_sel_o, 0);
        check("l4_abort_wt_base", wt_base_o, 0);
        check("l4_abort_last_pass", last_pass_o, 0);
        @(negedge clk_i);
        check("l4_ib_rst_one_cycle", ib_rst_o, 0);
        exp_q.delete();
        repeat (20) @(negedge clk_i);
        check("l4_row_starts", rs_cnt - rs0, 21);
        check("l4_ib_rst_total", ib_cnt - ib0, 3);
        check("l4_no_done", done_cnt - dn0, 0);

        // Layer 5: spurious row_done_i in IDLE and in ROW_START.
        set_cfg(4, 2, 2, 3, 9);
        build_model(4, 2, 2, 3, 9);
        rs0 = rs_cnt; ib0 = ib_cnt; dn0 = done_cnt;
        @(posedge clk_i); #1 row_done_i = 1'b1;
        @(posedge clk_i); #1 row_done_i = 1'b0;
        @(negedge clk_i);
        check("l5_idle_spurious_busy", busy_o, 0);
        check("l5_idle_spurious_rows", rs_cnt - rs0, 0);
        pulse_start();
        wait_row_start(ok);
        check("l5_first_start", ok, 1);
        row_done_i = 1'b1;
        @(posedge clk_i); #1 row_done_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("l5_spurious_ignored", rs_cnt - rs0, 1);
        repeat (2) @(posedge clk_i);
        #1 row_done_i = 1'b1;
        @(posedge clk_i); #1 row_done_i = 1'b0;
        serve_rows(5);
        wait_done();
        repeat (2) @(negedge clk_i);
        check("l5_row_starts", rs_cnt - rs0, 6);
        check("l5_ib_rst", ib_cnt - ib0, 2);
        check("l5_done_pulses", done_cnt - dn0, 1);
        check("l5_model_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
